// File: rtl/mips_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide unit.
package mips_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned MD_OP_W     = 3;
  localparam int unsigned MD_CNT_W    = 5;
  localparam int unsigned MD_CNT_LAST = 31;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // True for the four ops that run through the iterative datapath.
  function automatic logic md_is_iter(input logic [MD_OP_W-1:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the ops whose operands are two's complement.
  function automatic logic md_is_signed(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // True for the divide ops.
  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_datapath.sv
// Shift-add multiplier / restoring divider with sign fix-up of the results.
module muldiv_datapath
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = mips_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               step,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  output logic [WIDTH-1:0]   res_hi_c,
  output logic [WIDTH-1:0]   res_lo_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic             is_div_q;
  logic             res_neg_q;
  logic             rem_neg_q;
  logic             dvz_q;
  logic [WIDTH-1:0] raw_rs_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [PW-1:0]    acc_q;

  logic             is_div_c;
  logic             rs_neg_c;
  logic             rt_neg_c;
  logic [WIDTH-1:0] rs_mag_c;
  logic [WIDTH-1:0] rt_mag_c;

  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   part_rem_c;
  logic             ge_c;
  logic [WIDTH-1:0] sub_c;

  logic [PW-1:0]    prod_c;
  logic [WIDTH-1:0] quo_fix_c;
  logic [WIDTH-1:0] rem_fix_c;

  // Operand signs and magnitudes presented at accept time.
  always_comb begin
    is_div_c = md_is_div(op);
    rs_neg_c = md_is_signed(op) && rs[WIDTH-1];
    rt_neg_c = md_is_signed(op) && rt[WIDTH-1];
    rs_mag_c = rs_neg_c ? ((~rs) + WIDTH'(1)) : rs;
    rt_mag_c = rt_neg_c ? ((~rt) + WIDTH'(1)) : rt;
  end

  // One iteration: conditional add of the multiplicand, or a trial subtract
  // of the divisor from the 33-bit shifted partial remainder.
  always_comb begin
    sum_c      = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
    part_rem_c = {rem_q, quo_q[WIDTH-1]};
    ge_c       = (part_rem_c >= {1'b0, opb_q});
    sub_c      = part_rem_c[WIDTH-1:0] - opb_q;
  end

  // Latch operands on accept, then advance one bit per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dvz_q     <= 1'b0;
      raw_rs_q  <= '0;
      opb_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
    end else if (start) begin
      is_div_q  <= is_div_c;
      res_neg_q <= rs_neg_c ^ rt_neg_c;
      rem_neg_q <= rs_neg_c;
      dvz_q     <= is_div_c && (rt == '0);
      raw_rs_q  <= rs;
      opb_q     <= is_div_c ? rt_mag_c : rs_mag_c;
      acc_q     <= {WIDTH'(0), rt_mag_c};
      quo_q     <= rs_mag_c;
      rem_q     <= '0;
    end else if (step) begin
      if (is_div_q) begin
        rem_q <= ge_c ? sub_c : part_rem_c[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ge_c};
      end else begin
        acc_q <= {sum_c, acc_q[WIDTH-1:1]};
      end
    end
  end

  // Sign fix-up and special divide cases feeding the HI/LO write in FIX.
  always_comb begin
    prod_c    = res_neg_q ? ((~acc_q) + PW'(1)) : acc_q;
    quo_fix_c = res_neg_q ? ((~quo_q) + WIDTH'(1)) : quo_q;
    rem_fix_c = rem_neg_q ? ((~rem_q) + WIDTH'(1)) : rem_q;
    res_hi_c  = prod_c[PW-1:WIDTH];
    res_lo_c  = prod_c[WIDTH-1:0];
    if (is_div_q) begin
      if (dvz_q) begin
        // Divide by zero: all-ones quotient, dividend left untouched in HI.
        res_hi_c = raw_rs_q;
        res_lo_c = '1;
      end else begin
        res_hi_c = rem_fix_c;
        res_lo_c = quo_fix_c;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with HI/LO registers and stall request.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = mips_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MD_OP_W-1:0] i_EX_ctrl_MDOp,
  input  logic               i_EX_ctrl_MDValid,
  input  logic               i_EX_ctrl_HiLoRead,
  input  logic [WIDTH-1:0]   i_EX_data_RSData,
  input  logic [WIDTH-1:0]   i_EX_data_RTData,
  output logic [WIDTH-1:0]   o_EX_data_HI,
  output logic [WIDTH-1:0]   o_EX_data_LO,
  output logic               o_busy,
  output logic               o_stall
);

  md_state_e           state_q;
  md_state_e           state_d;
  logic [MD_CNT_W-1:0] count_q;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic [WIDTH-1:0]    res_hi_c;
  logic [WIDTH-1:0]    res_lo_c;

  logic idle_c;
  logic accept_c;
  logic mthi_c;
  logic mtlo_c;

  // Request decode; everything is only taken while idle.
  always_comb begin
    idle_c   = (state_q == MD_IDLE);
    accept_c = idle_c && i_EX_ctrl_MDValid && md_is_iter(i_EX_ctrl_MDOp);
    mthi_c   = idle_c && i_EX_ctrl_MDValid && (i_EX_ctrl_MDOp == MD_MTHI);
    mtlo_c   = idle_c && i_EX_ctrl_MDValid && (i_EX_ctrl_MDOp == MD_MTLO);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE -> CALC (32 iterations) -> FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (accept_c) state_d = MD_CALC;
      MD_CALC: if (count_q == MD_CNT_W'(MD_CNT_LAST)) state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // Iteration counter, cleared on accept and advanced once per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept_c) begin
      count_q <= '0;
    end else if (state_q == MD_CALC) begin
      count_q <= count_q + MD_CNT_W'(1);
    end
  end

  // HI/LO: written by FIX results or by MTHI/MTLO while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == MD_FIX) begin
      hi_q <= res_hi_c;
      lo_q <= res_lo_c;
    end else begin
      if (mthi_c) hi_q <= i_EX_data_RSData;
      if (mtlo_c) lo_q <= i_EX_data_RSData;
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .start    (accept_c),
    .step     (state_q == MD_CALC),
    .op       (i_EX_ctrl_MDOp),
    .rs       (i_EX_data_RSData),
    .rt       (i_EX_data_RTData),
    .res_hi_c (res_hi_c),
    .res_lo_c (res_lo_c)
  );

  // Busy follows the state register; stall holds any MD op or HI/LO read while busy.
  always_comb begin
    o_busy       = !idle_c;
    o_stall      = o_busy && ((i_EX_ctrl_MDValid && (i_EX_ctrl_MDOp != MD_NOP)) ||
                              i_EX_ctrl_HiLoRead);
    o_EX_data_HI = hi_q;
    o_EX_data_LO = lo_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: arithmetic reference model plus directed literals.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  md_op;
  logic        md_valid;
  logic        hilo_rd;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (spec-level: countdown of busy cycles + pending result).
  int          remaining = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  bit          started = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_EX_ctrl_MDOp     (md_op),
    .i_EX_ctrl_MDValid  (md_valid),
    .i_EX_ctrl_HiLoRead (hilo_rd),
    .i_EX_data_RSData   (rs_data),
    .i_EX_data_RTData   (rt_data),
    .o_EX_data_HI       (hi),
    .o_EX_data_LO       (lo),
    .o_busy             (busy),
    .o_stall            (stall)
  );

  always #5 clk = ~clk;

  // Architectural result of an iterative op computed with plain arithmetic.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    int          sa;
    int          sb;
    longint      sp;
    logic [63:0] up;
    sa = a;
    sb = b;
    h = '0;
    l = '0;
    case (op)
      3'd1: begin sp = longint'(sa) * longint'(sb); {h, l} = sp; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
      3'd3: begin
        if (b == 32'd0) begin l = 32'hFFFFFFFF; h = a; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = 32'h80000000; h = 32'd0; end
        else begin l = sa / sb; h = sa % sb; end
      end
      3'd4: begin
        if (b == 32'd0) begin l = 32'hFFFFFFFF; h = a; end
        else begin l = a / b; h = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Cycle model: an accepted op keeps the unit busy 33 cycles, then HI/LO update.
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      remaining = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (remaining > 0) begin
      remaining = remaining - 1;
      if (remaining == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (md_valid) begin
      case (md_op)
        3'd1, 3'd2, 3'd3, 3'd4: begin
          ref_md(md_op, rs_data, rt_data, p_hi, p_lo);
          remaining = 33;
        end
        3'd5: m_hi = rs_data;
        3'd6: m_lo = rs_data;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Every cycle: DUT outputs against the model.
  task automatic compare_loop();
    logic exp_stall;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_stall = (remaining > 0) && ((md_valid && md_op != 3'd0) || hilo_rd);
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
        chk("cyc_busy", {31'd0, busy}, {31'd0, remaining > 0});
        chk("cyc_stall", {31'd0, stall}, {31'd0, exp_stall});
      end
    end
  endtask

  // Present a request and hold it, as the hazard unit would, until not stalled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rd);
    logic s;
    int   guard;
    md_op = op; md_valid = 1'b1; hilo_rd = rd; rs_data = a; rt_data = b;
    guard = 0;
    forever begin
      @(negedge clk);
      s = stall;
      @(posedge clk);
      #1;
      if (!s) break;
      guard++;
      if (guard > 200) begin
        n_cmp++; n_bad++;
        $display("FAIL issue_timeout: stall still 1 after %0d cycles, expected 0", guard);
        break;
      end
    end
    md_op = 3'd0; md_valid = 1'b0; hilo_rd = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (remaining > 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (remaining > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: model still busy %0d, expected 0", remaining);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1'b0);
    wait_idle();
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'hFFFFFFFF;
      2: v = 32'h80000000;
      3: v = 32'd1;
      4: v = $urandom_range(0, 50);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int nb;
    int nst;
    rst = 1'b1; md_op = 3'd0; md_valid = 1'b0; hilo_rd = 1'b0; rs_data = '0; rt_data = '0;
    fork
      compare_loop();
    join_none
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    // MULTU max x max, with busy duration.
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    nb = 0;
    forever begin
      @(negedge clk);
      if (!busy || nb >= 100) break;
      nb++;
    end
    chk("multu_busy_cycles", nb, 32'd33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    @(posedge clk);
    #1;

    run(3'd1, 32'hFFFFFFFD, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);
    run(3'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    run(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);
    run(3'd4, 32'd100, 32'd0);
    chk("divu_dvz_lo", lo, 32'hFFFFFFFF);
    chk("divu_dvz_hi", hi, 32'h00000064);
    run(3'd3, 32'hFFFFFFF7, 32'd0);
    chk("div_dvz_lo", lo, 32'hFFFFFFFF);
    chk("div_dvz_hi", hi, 32'hFFFFFFF7);

    // MFLO arriving at cycle 5 of a MULTU 7x6 stalls until results land.
    issue(3'd2, 32'd7, 32'd6, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    hilo_rd = 1'b1;
    nst = 0;
    forever begin
      @(negedge clk);
      if (!stall || nst >= 100) break;
      nst++;
    end
    chk("mflo_stall_cycles", nst, 32'd29);
    chk("mflo_lo", lo, 32'd42);
    chk("mflo_hi", hi, 32'd0);
    @(posedge clk);
    #1;
    hilo_rd = 1'b0;

    // MTLO behind a MULT is held, then applied after the MULT finishes.
    issue(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    issue(3'd6, 32'h12345678, 32'd0, 1'b0);
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi", hi, 32'hFFFFFFFF);
    run(3'd5, 32'hCAFEF00D, 32'd0);
    chk("mthi_hi", hi, 32'hCAFEF00D);

    // Reset at cycle 10 of a MULT discards it.
    issue(3'd1, 32'd5, 32'd7, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    run(3'd2, 32'd3, 32'd4);
    chk("after_rst_lo", lo, 32'd12);

    // Randomized traffic, including back-to-back ops, reads and the odd reset.
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 14) == 0) begin
        repeat ($urandom_range(1, 30)) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    end
    wait_idle();
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
